s2p_deser: RTL and testbench



---
 rtl/s2p_deser.sv | 75 +++++++
 tb/tb_s2p_deser.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/s2p_deser.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : s2p_deser
// Description : Serial-to-parallel deserializer. Collects one bit per clka edge
//               while wra_n is low and emits each WIDTH-bit word with a pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module s2p_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clka,
    input  logic             rstn,
    input  logic             wra_n,
    input  logic             da,
    output logic             wrb,
    output logic [WIDTH-1:0] db
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic             wrb_q, wrb_d;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_next = {shift_q[WIDTH-2:0], da};
        end else begin : g_lsb_first
            assign shift_next = {da, shift_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        wrb_d   = 1'b0;
        if (!wra_n) begin
            shift_d = shift_next;
            if (cnt_q == CNT_LAST) begin
                // db takes the word including the bit captured on this edge
                cnt_d = '0;
                db_d  = shift_next;
                wrb_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clka) begin
        if (!rstn) begin
            shift_q <= '0;
            cnt_q   <= '0;
            db_q    <= '0;
            wrb_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            wrb_q   <= wrb_d;
        end
    end

    assign wrb = wrb_q;
    assign db  = db_q;

endmodule
`default_nettype wire

// File: tb/tb_s2p_deser.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_s2p_deser
// Description : Directed self-checking bench for s2p_deser, MSB- and LSB-first.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_s2p_deser;

    localparam int WIDTH = 8;

    logic             clka;
    logic             rstn;
    logic             wra_n;
    logic             da;
    logic             wrb_m;
    logic [WIDTH-1:0] db_m;
    logic             wrb_l;
    logic [WIDTH-1:0] db_l;

    int n_checks;
    int n_errors;

    s2p_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut_msb (
        .clka  (clka),
        .rstn  (rstn),
        .wra_n (wra_n),
        .da    (da),
        .wrb   (wrb_m),
        .db    (db_m)
    );

    s2p_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clka  (clka),
        .rstn  (rstn),
        .wra_n (wra_n),
        .da    (da),
        .wrb   (wrb_l),
        .db    (db_l)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one edge worth of inputs, then sample 1ns after the edge.
    task automatic step(input logic r, input logic w, input logic d);
        @(negedge clka);
        rstn  = r;
        wra_n = w;
        da    = d;
        @(posedge clka);
        #1;
    endtask

    // Send the 8 bits of word (MSB first on the wire), checking wrb every edge.
    task automatic send_word(input string tag, input logic [7:0] word,
                             input logic [7:0] exp_msb, input logic [7:0] exp_lsb);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, 1'b0, word[i]);
            check({tag, "_wrb_msb"}, 32'(wrb_m), (i == 0) ? 32'd1 : 32'd0);
            check({tag, "_wrb_lsb"}, 32'(wrb_l), (i == 0) ? 32'd1 : 32'd0);
        end
        check({tag, "_db_msb"}, 32'(db_m), 32'(exp_msb));
        check({tag, "_db_lsb"}, 32'(db_l), 32'(exp_lsb));
    endtask

    task automatic idle(input string tag, input logic [7:0] exp_msb, input logic [7:0] exp_lsb);
        step(1'b1, 1'b1, 1'bx);
        check({tag, "_wrb_msb"}, 32'(wrb_m), 32'd0);
        check({tag, "_wrb_lsb"}, 32'(wrb_l), 32'd0);
        check({tag, "_db_msb"}, 32'(db_m), 32'(exp_msb));
        check({tag, "_db_lsb"}, 32'(db_l), 32'(exp_lsb));
    endtask

    initial begin
        logic [7:0] part;
        n_checks = 0;
        n_errors = 0;
        rstn  = 1'b0;
        wra_n = 1'b0;
        da    = 1'b0;

        // Reset held with wra_n low and da toggling
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, i[0]);
            check("rst_db_msb", 32'(db_m), 32'h00);
            check("rst_wrb_msb", 32'(wrb_m), 32'd0);
            check("rst_db_lsb", 32'(db_l), 32'h00);
            check("rst_wrb_lsb", 32'(wrb_l), 32'd0);
        end

        // Single word 1,0,1,1,0,0,1,0 -> 0xB2 MSB-first, 0x4D LSB-first
        send_word("single", 8'hB2, 8'hB2, 8'h4D);
        idle("single_hold", 8'hB2, 8'h4D);
        idle("single_hold2", 8'hB2, 8'h4D);

        // Back-to-back words with wra_n held low
        send_word("b2b_a5", 8'hA5, 8'hA5, 8'hA5);
        send_word("b2b_3c", 8'h3C, 8'h3C, 8'h3C);
        idle("b2b_hold", 8'h3C, 8'h3C);

        // Abort after 5 bits, two idle edges, then a fresh 0xFF word
        part = 8'b1011_0000;
        for (int i = 7; i >= 3; i--) begin
            step(1'b1, 1'b0, part[i]);
            check("abort_part_wrb", 32'(wrb_m), 32'd0);
        end
        idle("abort_gap1", 8'h3C, 8'h3C);
        idle("abort_gap2", 8'h3C, 8'h3C);
        send_word("abort_ff", 8'hFF, 8'hFF, 8'hFF);

        // wra_n rises on the edge the 8th bit would have been captured
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("short7_wrb", 32'(wrb_m), 32'd0);
        end
        idle("short7_end", 8'hFF, 8'hFF);

        // Reset mid-word after a completed 0xB2
        send_word("pre_rst", 8'hB2, 8'hB2, 8'h4D);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b1);
        check("midrst_db_msb", 32'(db_m), 32'h00);
        check("midrst_db_lsb", 32'(db_l), 32'h00);
        check("midrst_wrb", 32'(wrb_m), 32'd0);
        send_word("post_rst", 8'h81, 8'h81, 8'h81);
        idle("post_rst_hold", 8'h81, 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
